seg7_display_arbiter: RTL and testbench

Time-shares the 4-digit multiplexed 7-segment display, and the shared 8-bit binary-to-BCD converter in front of it, between two 8-bit value sources. A round-robin arbiter grants the display to one requester for a programmable number of scan frames. A scan controller sequences the digit commons with a ghost-suppression blanking window and leading-zero suppression. Its digit outputs feed the existing 4-bit-to-7-segment decoder.

---
 rtl/seg7_display_arbiter_if.sv | 11 +
 rtl/seg7_display_arbiter.sv | 61 ++++++
 tb/tb_seg7_display_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/seg7_display_arbiter_if.sv
// seg7_display_arbiter_if: requester, converter and display signals of the shared 7-segment display.
interface seg7_display_arbiter_if;
    logic [1:0] REQ;
    logic [7:0] BIN0, BIN1;
    logic [3:0] ONES, TENS, HUNDREDS;
    logic [1:0] GNT;
    logic [7:0] BIN_SEL;
    logic [3:0] DIGIT, SEG7COM;
    modport master (output REQ, BIN0, BIN1, ONES, TENS, HUNDREDS, input GNT, BIN_SEL, DIGIT, SEG7COM);
    modport slave (input REQ, BIN0, BIN1, ONES, TENS, HUNDREDS, output GNT, BIN_SEL, DIGIT, SEG7COM);
endinterface

// File: rtl/seg7_display_arbiter.sv
// seg7_display_arbiter: round-robin time-sharing of a 4-digit multiplexed display between two sources.
module seg7_display_arbiter #(
    parameter int PRESCALE = 250000,
    parameter int BLANK = 2500,
    parameter int DWELL = 200
) (
    input logic CLK,
    input logic RSTn,
    seg7_display_arbiter_if.slave bus
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam int FW = $clog2(DWELL + 1);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PBL = PW'(BLANK);
    localparam logic [FW-1:0] DW1 = FW'(DWELL - 1);
    typedef enum logic [1:0] {IDLE = 2'b00, SHOW0 = 2'b01, SHOW1 = 2'b10} state_t;
    state_t state, nxt;
    logic [PW-1:0] presc;
    logic [1:0] slot;
    logic [FW-1:0] fcnt;
    logic last, frame_end, dark, lit;
    logic [3:0] code;
    assign frame_end = slot == 2'd3 && presc == PMAX;
    assign bus.GNT = state;
    always_comb begin
        nxt = state;
        if (frame_end)
            case (state)
                IDLE: nxt = bus.REQ == 2'b11 ? (last ? SHOW0 : SHOW1) : bus.REQ[0] ? SHOW0 : bus.REQ[1] ? SHOW1 : IDLE;
                SHOW0: nxt = !bus.REQ[0] ? (bus.REQ[1] ? SHOW1 : IDLE) : fcnt >= DW1 && bus.REQ[1] ? SHOW1 : SHOW0;
                SHOW1: nxt = !bus.REQ[1] ? (bus.REQ[0] ? SHOW0 : IDLE) : fcnt >= DW1 && bus.REQ[0] ? SHOW0 : SHOW1;
                default: nxt = IDLE;
            endcase
    end
    // leading zeros go dark, but DIGIT keeps carrying the code
    assign code = slot == 2'd0 ? bus.ONES : slot == 2'd1 ? bus.TENS : slot == 2'd2 ? bus.HUNDREDS : state == SHOW0 ? 4'hA : 4'hB;
    assign dark = (slot == 2'd2 && bus.HUNDREDS == 4'd0) || (slot == 2'd1 && bus.HUNDREDS == 4'd0 && bus.TENS == 4'd0);
    assign lit = state != IDLE && presc >= PBL && !dark;
    always_ff @(posedge CLK or negedge RSTn)
        if (!RSTn) begin
            state <= IDLE;
            last <= 1'b1;
            presc <= '0;
            slot <= '0;
            fcnt <= '0;
            bus.BIN_SEL <= '0;
            bus.DIGIT <= '0;
            bus.SEG7COM <= 4'hF;
        end else begin
            presc <= presc == PMAX ? '0 : presc + 1'b1;
            if (presc == PMAX) slot <= slot + 1'b1;
            state <= nxt;
            if (nxt != state) begin
                fcnt <= '0;
                if (nxt != IDLE) last <= nxt == SHOW1;
            end else if (frame_end && state != IDLE && fcnt < DW1) fcnt <= fcnt + 1'b1;
            bus.BIN_SEL <= nxt == SHOW0 ? bus.BIN0 : nxt == SHOW1 ? bus.BIN1 : 8'd0;
            bus.DIGIT <= state == IDLE ? 4'd0 : code;
            bus.SEG7COM <= lit ? ~(4'b0001 << slot) : 4'hF;
        end
endmodule

// File: tb/tb_seg7_display_arbiter.sv
// tb_seg7_display_arbiter: scoreboard bench; expected per-cycle outputs queued by cycle, checked by a monitor.
module tb_seg7_display_arbiter;
    typedef struct {int t; int kind; logic [7:0] val;} chk_t;
    logic CLK = 1'b0, RSTn;
    int t = 0, vectors = 0, miscompares = 0;
    chk_t q[$];
    chk_t e;
    logic [7:0] act;
    string names[4] = '{"GNT", "DIGIT", "SEG7COM", "BIN_SEL"};
    seg7_display_arbiter_if bus();
    seg7_display_arbiter #(.PRESCALE(8), .BLANK(2), .DWELL(2)) dut (.CLK(CLK), .RSTn(RSTn), .bus(bus));
    // behavioural stand-in for the shared binary-to-BCD converter
    assign bus.ONES = 4'(bus.BIN_SEL % 8'd10);
    assign bus.TENS = 4'((bus.BIN_SEL / 8'd10) % 8'd10);
    assign bus.HUNDREDS = 4'(bus.BIN_SEL / 8'd100);
    always #5 CLK = ~CLK;
    always @(posedge CLK or negedge RSTn)
        if (!RSTn) t <= 0;
        else t <= t + 1;
    always @(negedge CLK)
        while (q.size() > 0 && q[0].t <= t) begin
            e = q.pop_front();
            case (e.kind)
                0: act = {6'd0, bus.GNT};
                1: act = {4'd0, bus.DIGIT};
                2: act = {4'd0, bus.SEG7COM};
                default: act = bus.BIN_SEL;
            endcase
            vectors++;
            if (e.t != t || act != e.val) begin
                miscompares++;
                $display("FAIL %s at cycle %0d (due %0d): got %h, expected %h", names[e.kind], t, e.t, act, e.val);
            end
        end
    task automatic push(input int tt, input int k, input logic [7:0] v);
        q.push_back(chk_t'{t: tt, kind: k, val: v});
    endtask
    task automatic push_reset();
        push(0, 0, 8'h00);
        push(0, 1, 8'h00);
        push(0, 2, 8'h0F);
        push(0, 3, 8'h00);
    endtask
    // dg = {tag, hundreds, tens, ones}; mask bit s = slot s lit
    task automatic push_frame(input int f, input logic [1:0] g, input logic [7:0] bs, input logic [15:0] dg,
                              input logic [3:0] mask, input int lim = 1 << 30);
        for (int c = 0; c < 32; c++) begin
            int tt = 32 * f + c;
            int p = c - 1;
            int s = p / 8;
            if (tt >= lim) return;
            if (c == 0 || c == 16 || c == 31) push(tt, 0, {6'd0, g});
            if (c == 1) push(tt, 3, bs);
            if (c > 0) begin
                push(tt, 1, {4'd0, dg[4*s +: 4]});
                push(tt, 2, {4'd0, (mask[s] && p % 8 >= 2) ? ~(4'b0001 << s) : 4'hF});
            end
        end
    endtask
    task automatic wait_t(input int n);
        for (int i = 0; i < 20000 && t < n; i++) @(negedge CLK);
    endtask
    initial begin
        RSTn = 1'b1;
        bus.REQ = 2'b00;
        bus.BIN0 = 8'd205;
        bus.BIN1 = 8'd42;
        #1 RSTn = 1'b0;
        push_reset();
        push_frame(0, 2'b00, 8'd0, 16'h0000, 4'b0000);
        push_frame(1, 2'b00, 8'd0, 16'h0000, 4'b0000);
        push_frame(2, 2'b00, 8'd0, 16'h0000, 4'b0000);
        push_frame(3, 2'b01, 8'd205, 16'hA205, 4'b1111);
        push_frame(4, 2'b01, 8'd205, 16'hA205, 4'b1111);
        push_frame(5, 2'b10, 8'd42, 16'hB042, 4'b1011);
        push_frame(6, 2'b10, 8'd42, 16'hB042, 4'b1011);
        push_frame(7, 2'b01, 8'd205, 16'hA205, 4'b1111);
        push_frame(8, 2'b01, 8'd205, 16'hA205, 4'b1111);
        push_frame(9, 2'b01, 8'd7, 16'hA007, 4'b1001);
        push_frame(10, 2'b00, 8'd0, 16'h0000, 4'b0000);
        push_frame(11, 2'b10, 8'd42, 16'hB042, 4'b1011);
        push_frame(12, 2'b10, 8'd42, 16'hB042, 4'b1011, 397);
        repeat (3) @(negedge CLK);
        #1 RSTn = 1'b1;
        wait_t(40); bus.REQ = 2'b10;
        wait_t(50); bus.REQ = 2'b00;
        wait_t(70); bus.REQ = 2'b11;
        wait_t(229); bus.REQ = 2'b01;
        wait_t(287); bus.BIN0 = 8'd7;
        wait_t(301); bus.REQ = 2'b00;
        wait_t(325); bus.REQ = 2'b11;
        wait_t(396);
        @(posedge CLK);
        #1 RSTn = 1'b0;
        bus.BIN0 = 8'd205;
        push_reset();
        push_frame(0, 2'b00, 8'd0, 16'h0000, 4'b0000);
        push_frame(1, 2'b01, 8'd205, 16'hA205, 4'b1111);
        push_frame(2, 2'b01, 8'd205, 16'hA205, 4'b1111);
        push_frame(3, 2'b10, 8'd42, 16'hB042, 4'b1011);
        @(posedge CLK);
        #1 RSTn = 1'b1;
        for (int i = 0; i < 400 && q.size() > 0; i++) @(negedge CLK);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d checks left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
